// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold, release and hold-limit timeout.
// All outputs are registered; owner is lowest priority at each re-arbitration.
module rr_arbiter #(
   parameter int unsigned N        = 3,
   parameter int unsigned IDX_W    = (N > 2) ? $clog2(N) : 1,
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N-1:0]     req_i,
   input  logic             release_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_valid_o,
   output logic             timeout_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
   localparam logic [N-1:0]     ONE       = N'(1);
   localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N - 1);

   state_t           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     cand;
   logic             found;
   logic [IDX_W-1:0] win;
   logic             own_req;
   logic             hit_limit;
   logic             end_grant;

   // Scan starts one past last; offset N lands back on last so the owner ranks lowest.
   always_comb begin
      cand      = req_i;
      found     = 1'b0;
      win       = '0;
      own_req   = req_i[last_q];
      hit_limit = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
      end_grant = release_i | ~own_req | hit_limit;
      if (state_q == BUSY && release_i) begin
         cand[last_q] = 1'b0;
      end
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned pos;
         pos = (int'(last_q) + k) % N;
         if (!found && cand[pos]) begin
            found = 1'b1;
            win   = IDX_W'(pos);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      last_d    = last_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               grant_d = ONE << win;
               idx_d   = win;
               valid_d = 1'b1;
               last_d  = win;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (!end_grant) begin
               if (HOLD_MAX != 0 && cnt_q != HOLD_LAST) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               timeout_d = hit_limit & ~release_i & own_req;
               cnt_d     = '0;
               if (found) begin
                  grant_d = ONE << win;
                  idx_d   = win;
                  last_d  = win;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_idx_o   = idx_q;
   assign grant_valid_o = valid_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=3, HOLD_MAX=8) with hand-computed expectations.
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic       rel;
   logic [2:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   rr_arbiter #(.N(3), .HOLD_MAX(8)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .req_i         (req),
      .release_i     (rel),
      .grant_o       (grant),
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid),
      .timeout_o     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [2:0] g, input logic [1:0] idx,
                            input logic v, input logic to);
      check_eq({tag, ".grant"}, 32'(grant), 32'(g));
      check_eq({tag, ".idx"}, 32'(grant_idx), 32'(idx));
      check_eq({tag, ".valid"}, 32'(grant_valid), 32'(v));
      check_eq({tag, ".timeout"}, 32'(timeout), 32'(to));
   endtask

   initial begin
      logic [2:0] rot_g [3];
      logic [1:0] rot_i [3];
      rot_g = '{3'b010, 3'b100, 3'b001};
      rot_i = '{2'd1, 2'd2, 2'd0};

      // Reset, with requests present during the second reset cycle
      reset = 1'b1; req = 3'b000; rel = 1'b0;
      tick();
      check_out("rst0", 3'b000, 2'd0, 1'b0, 1'b0);
      req = 3'b111;
      tick();
      check_out("rst1", 3'b000, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      check_out("first", 3'b001, 2'd0, 1'b1, 1'b0);

      // Rotation via release, no idle bubble
      for (int i = 0; i < 3; i++) begin
         rel = 1'b1;
         tick();
         rel = 1'b0;
         check_out($sformatf("rot%0d", i), rot_g[i], rot_i[i], 1'b1, 1'b0);
      end

      // Hold-limit timeout between two requesters
      req = 3'b011;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_out($sformatf("hold0_%0d", i), 3'b001, 2'd0, 1'b1, 1'b0);
      end
      tick();
      check_out("to_sw1", 3'b010, 2'd1, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_out($sformatf("hold1_%0d", i), 3'b010, 2'd1, 1'b1, 1'b0);
      end
      tick();
      check_out("to_sw0", 3'b001, 2'd0, 1'b1, 1'b1);

      // Sole requester: drop of owner moves grant, then repeated self re-grant on timeout
      req = 3'b100;
      tick();
      check_out("sole_start", 3'b100, 2'd2, 1'b1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 7; i++) begin
            tick();
            check_eq($sformatf("sole_g%0d_%0d", r, i), 32'(grant), 32'(3'b100));
            check_eq($sformatf("sole_t%0d_%0d", r, i), 32'(timeout), 32'd0);
         end
         tick();
         check_out($sformatf("sole_to%0d", r), 3'b100, 2'd2, 1'b1, 1'b1);
      end

      // Request drop to idle, release while idle, then scan after last=1
      req = 3'b010;
      tick();
      check_out("drop_a", 3'b010, 2'd1, 1'b1, 1'b0);
      req = 3'b000;
      tick();
      check_out("idle", 3'b000, 2'd0, 1'b0, 1'b0);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check_out("idle_rel", 3'b000, 2'd0, 1'b0, 1'b0);
      req = 3'b101;
      tick();
      check_out("after_idle", 3'b100, 2'd2, 1'b1, 1'b0);

      // Reset mid-grant with hold count at 5
      req = 3'b010;
      tick();
      check_out("mid_a", 3'b010, 2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("mid_hold%0d", i), 32'(grant), 32'(3'b010));
      end
      req = 3'b111;
      reset = 1'b1;
      tick();
      check_out("mid_rst", 3'b000, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      check_out("post_rst", 3'b001, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("post_hold%0d", i), 3'b001, 2'd0, 1'b1, 1'b0);
      end

      // Release by sole requester: owner is excluded, so arbiter goes idle
      req = 3'b001;
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check_out("rel_sole", 3'b000, 2'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource (a bank of Bits muxes) among N requesters.
- Drives a one-hot grant vector and a binary select index. The index feeds the resource's mux select tree directly.
- Holds each grant until the owner releases, drops its request, or exceeds a hold limit.
- Guarantees no requester starves while its request stays asserted.

Parameters:
- N, 3, number of requesters (legal 2..8).
- IDX_W, clog2(N) (min 1), width of grant_idx.
- HOLD_MAX, 8, maximum consecutive cycles of one grant; 0 disables the timeout.
- CNT_W, clog2(HOLD_MAX+1) (min 1), width of the hold counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- release  input  1  single-cycle pulse from the current owner: done this cycle.
- grant  output  N  one-hot grant, all-zero when idle.
- grant_idx  output  IDX_W  binary index of the owner; 0 when idle.
- grant_valid  output  1  high when grant is non-zero.
- timeout  output  1  one-cycle pulse in the cycle a grant is revoked by HOLD_MAX.

Behaviour:
- All outputs are registered.
- Reset (RESET=1 at an edge):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0, hold_cnt=0.
  - last=N-1, so requester 0 has top priority after reset.
  - State=IDLE.
  - Reset overrides every other input in the same cycle, including mid-grant; no timeout pulse is produced.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0 at an edge, choose winner w = first set bit of req scanning (last+1) mod N, (last+2) mod N, ..., wrapping.
  - At that edge: grant=1<<w, grant_idx=w, grant_valid=1, last=w, hold_cnt=0, go to BUSY.
  - Latency is one cycle from req sampled to grant visible.
  - If req==0, stay in IDLE with outputs at zero.
- BUSY, end-of-grant condition E = release | ~req[owner] | (HOLD_MAX!=0 & hold_cnt==HOLD_MAX-1).
  - If E is false: hold grant, hold_cnt += 1 (saturates at HOLD_MAX-1, never wraps).
  - If E is true: select the next winner from current req, scanning from owner+1 with wrap.
    - The owner is lowest priority. It is re-granted only if req[owner]=1, release=0, and it is the sole requester. This case applies only on timeout: the same index is re-granted and hold_cnt resets to 0.
    - If a winner exists: switch grant at that edge with no idle bubble; last=winner; hold_cnt=0; stay in BUSY.
    - If no winner: grant=0, grant_idx=0, grant_valid=0, go to IDLE.
- timeout=1 for exactly the cycle after the edge at which E was true solely due to the hold limit, i.e. release=0 and req[owner]=1.
- Release while idle is ignored. Release and a request drop in the same cycle count as one end-of-grant event.
- Grant is always one-hot or zero; never more than one bit set.
- Requests on bits that are not granted have no effect until the next arbitration point.
- Maximum wait for a continuously asserting requester: (N-1)*HOLD_MAX cycles after its request, plus 1.

Test Plan:
- Reset/priority: N=3. RESET for 2 cycles, then req=3'b111 -> grant=001, grant_idx=0 one cycle later, grant_valid=1; all outputs 0 during reset.
- Rotation via release: req=111, pulse release each time a new grant appears -> grant sequence 001, 010, 100, 001, each switch occurring at the release edge with no zero cycle between grants.
- Timeout: HOLD_MAX=8, req=3'b011 held, release never pulsed -> grant=001 for exactly 8 cycles, then 010 for 8 cycles. timeout=1 for one cycle coincident with each first cycle of the new grant.
- Sole requester timeout: req=3'b100 held -> grant=100 continuously; timeout pulses every 8 cycles; grant never deasserts.
- Request drop and idle: grant=010 with req=010, then req->000 -> grant=000, grant_valid=0 the next cycle. Then req=101 -> grant=100 (scan starts after last=1).
- Reset mid-grant: grant=010 with hold_cnt=5, assert RESET one cycle with req=111 -> outputs 0, then grant=001 (last reset to N-1); timeout never pulses.
